// File: rtl/fpu_ss_pkg.sv
// Shared types for the FPU subsystem issue/retire path: write-back source,
// tag-table entry and decoded op class.
package fpu_ss_pkg;

  typedef enum logic [1:0] {
    WB_FPU    = 2'd0,
    WB_LOAD   = 2'd1,
    WB_DIRECT = 2'd2
  } wb_src_e;

  typedef enum logic [1:0] {
    OP_DIRECT = 2'd0,
    OP_FPU    = 2'd1,
    OP_LOAD   = 2'd2,
    OP_STORE  = 2'd3
  } op_class_e;

  typedef struct packed {
    logic [4:0] rd;
    logic       rd_is_fp;
  } tag_entry_t;

  function automatic op_class_e classify(input logic use_fpu, input logic is_load,
                                         input logic is_store);
    if (use_fpu) return OP_FPU;
    if (is_load) return OP_LOAD;
    if (is_store) return OP_STORE;
    return OP_DIRECT;
  endfunction

endpackage

// File: rtl/fpu_ss_scoreboard.sv
// FP-register busy bitmap with RAW/WAW hazard lookup on the registered state only.
// One set and one clear port per cycle; set wins on a same-bit collision.
module fpu_ss_scoreboard
  import fpu_ss_pkg::*;
#(
  parameter int NUM_FPR = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               set_i,
  input  logic [4:0]         set_addr_i,
  input  logic               clr_i,
  input  logic [4:0]         clr_addr_i,
  input  logic [14:0]        rs_addr_i,
  input  logic [2:0]         rs_used_i,
  input  logic [4:0]         rd_i,
  input  logic               rd_chk_i,
  output logic               hazard_o,
  output logic               rs2_busy_o,
  output logic [NUM_FPR-1:0] sb_o
);

  logic [NUM_FPR-1:0] sb_q, sb_d;

  always_comb begin
    sb_d = sb_q;
    if (clr_i) sb_d[clr_addr_i] = 1'b0;
    if (set_i) sb_d[set_addr_i] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) sb_q <= '0;
    else       sb_q <= sb_d;
  end

  always_comb begin
    hazard_o = rd_chk_i & sb_q[rd_i];
    for (int k = 0; k < 3; k++) begin
      if (rs_used_i[k] && sb_q[rs_addr_i[5*k +: 5]]) hazard_o = 1'b1;
    end
    rs2_busy_o = sb_q[rs_addr_i[9:5]];
  end

  assign sb_o = sb_q;

endmodule

// File: rtl/fpu_ss_issue.sv
// Issue/retire control for up to NUM_TAGS out-of-order FPU ops plus one load; issue is same-cycle.
// Stalls on scoreboard hazards, tag exhaustion or a busy write/response port; no internal skid.
module fpu_ss_issue
  import fpu_ss_pkg::*;
#(
  parameter int NUM_TAGS = 4,
  parameter int NUM_FPR  = 32,
  parameter int TAG_W    = $clog2(NUM_TAGS)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             instr_valid_i,
  output logic             instr_ready_o,
  input  logic [14:0]      rs_addr_i,
  input  logic [2:0]       rs_used_i,
  input  logic [4:0]       rd_i,
  input  logic             rd_is_fp_i,
  input  logic             use_fpu_i,
  input  logic             is_load_i,
  input  logic             is_store_i,
  output logic             fpu_in_valid_o,
  input  logic             fpu_in_ready_i,
  output logic [TAG_W-1:0] fpu_tag_o,
  input  logic             fpu_out_valid_i,
  output logic             fpu_out_ready_o,
  input  logic [TAG_W-1:0] fpu_tag_i,
  output logic             mem_q_valid_o,
  input  logic             mem_q_ready_i,
  input  logic             mem_p_valid_i,
  output logic             mem_p_ready_o,
  output logic             fpr_we_o,
  output logic [4:0]       fpr_waddr_o,
  output logic [1:0]       fpr_wsrc_o,
  output logic             c_p_valid_o,
  input  logic             c_p_ready_i,
  output logic [4:0]       c_p_rd_o,
  output logic             c_p_src_o,
  output logic             busy_o
);

  logic [NUM_TAGS-1:0] free_q, free_d;
  tag_entry_t          tag_tbl_q [NUM_TAGS];
  logic                load_busy_q, load_busy_d;
  logic [4:0]          load_rd_q, load_rd_d;

  op_class_e           cls;
  logic                go, hazard, rs2_busy, tag_free;
  logic [TAG_W-1:0]    alloc_tag;
  tag_entry_t          ret_e;
  logic                ret_live, load_wr, fpu_fp_req, fpu_cp_req, fpu_ret;
  logic                fpu_fire, load_fire, direct_fp, direct_c;
  logic                sb_set, sb_clr;
  logic [4:0]          sb_clr_addr;
  logic [NUM_FPR-1:0]  sb_vec;

  fpu_ss_scoreboard #(.NUM_FPR(NUM_FPR)) u_sb (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .set_i      (sb_set),
    .set_addr_i (rd_i),
    .clr_i      (sb_clr),
    .clr_addr_i (sb_clr_addr),
    .rs_addr_i  (rs_addr_i),
    .rs_used_i  (rs_used_i),
    .rd_i       (rd_i),
    .rd_chk_i   (rd_is_fp_i | (cls == OP_LOAD)),
    .hazard_o   (hazard),
    .rs2_busy_o (rs2_busy),
    .sb_o       (sb_vec)
  );

  // Lowest free tag; only tags free in the registered bitmap are candidates.
  always_comb begin
    alloc_tag = '0;
    for (int i = NUM_TAGS - 1; i >= 0; i--) begin
      if (free_q[i]) alloc_tag = TAG_W'(i);
    end
  end

  always_comb begin
    cls        = classify(use_fpu_i, is_load_i, is_store_i);
    go         = instr_valid_i & ~rst_i;
    tag_free   = |free_q;
    ret_e      = tag_tbl_q[fpu_tag_i];
    ret_live   = ~free_q[fpu_tag_i];
    load_wr    = ~rst_i & load_busy_q & mem_p_valid_i;
    fpu_out_ready_o = ~rst_i & (ret_e.rd_is_fp ? ~mem_p_valid_i : c_p_ready_i);
    fpu_fp_req = ~rst_i & fpu_out_valid_i & ret_live & ret_e.rd_is_fp;
    fpu_cp_req = ~rst_i & fpu_out_valid_i & ret_live & ~ret_e.rd_is_fp;
    fpu_ret    = fpu_out_valid_i & fpu_out_ready_o & ret_live;

    instr_ready_o  = 1'b0;
    fpu_in_valid_o = 1'b0;
    mem_q_valid_o  = 1'b0;
    fpu_fire       = 1'b0;
    load_fire      = 1'b0;
    direct_fp      = 1'b0;
    direct_c       = 1'b0;
    case (cls)
      OP_FPU: begin
        fpu_in_valid_o = go & ~hazard & tag_free;
        fpu_fire       = fpu_in_valid_o & fpu_in_ready_i;
        instr_ready_o  = fpu_fire;
      end
      OP_LOAD: begin
        mem_q_valid_o = go & ~hazard & ~load_busy_q;
        load_fire     = mem_q_valid_o & mem_q_ready_i;
        instr_ready_o = load_fire;
      end
      OP_STORE: begin
        mem_q_valid_o = go & ~hazard & ~rs2_busy & ~load_busy_q;
        instr_ready_o = mem_q_valid_o & mem_q_ready_i;
      end
      default: begin
        // Direct ops sit at the bottom of both the FPR-port and response priority.
        direct_fp     = go & ~hazard & rd_is_fp_i & ~load_wr & ~fpu_fp_req;
        direct_c      = go & ~hazard & ~rd_is_fp_i & ~fpu_cp_req;
        instr_ready_o = direct_fp | (direct_c & c_p_ready_i);
      end
    endcase

    fpr_we_o    = load_wr | (fpu_ret & ret_e.rd_is_fp) | direct_fp;
    fpr_waddr_o = '0;
    fpr_wsrc_o  = WB_FPU;
    if (load_wr) begin
      fpr_waddr_o = load_rd_q;
      fpr_wsrc_o  = WB_LOAD;
    end else if (fpu_ret && ret_e.rd_is_fp) begin
      fpr_waddr_o = ret_e.rd;
      fpr_wsrc_o  = WB_FPU;
    end else if (direct_fp) begin
      fpr_waddr_o = rd_i;
      fpr_wsrc_o  = WB_DIRECT;
    end

    c_p_valid_o = fpu_cp_req | direct_c;
    c_p_rd_o    = '0;
    c_p_src_o   = 1'b0;
    if (fpu_cp_req) begin
      c_p_rd_o = ret_e.rd;
    end else if (direct_c) begin
      c_p_rd_o  = rd_i;
      c_p_src_o = 1'b1;
    end

    fpu_tag_o     = rst_i ? '0 : alloc_tag;
    mem_p_ready_o = ~rst_i & load_busy_q;
    busy_o        = ~rst_i & (~(&free_q) | load_busy_q);

    sb_set      = (fpu_fire & rd_is_fp_i) | load_fire;
    sb_clr      = load_wr | (fpu_ret & ret_e.rd_is_fp);
    sb_clr_addr = load_wr ? load_rd_q : ret_e.rd;

    free_d = free_q;
    if (fpu_ret)  free_d[fpu_tag_i] = 1'b1;
    if (fpu_fire) free_d[alloc_tag] = 1'b0;

    load_busy_d = load_busy_q;
    load_rd_d   = load_rd_q;
    if (load_wr) load_busy_d = 1'b0;
    if (load_fire) begin
      load_busy_d = 1'b1;
      load_rd_d   = rd_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      free_q      <= '1;
      load_busy_q <= 1'b0;
      load_rd_q   <= '0;
      for (int i = 0; i < NUM_TAGS; i++) tag_tbl_q[i] <= '0;
    end else begin
      free_q      <= free_d;
      load_busy_q <= load_busy_d;
      load_rd_q   <= load_rd_d;
      if (fpu_fire) tag_tbl_q[alloc_tag] <= {rd_i, rd_is_fp_i};
    end
  end

  a_no_double_alloc: assert property (@(posedge clk_i) disable iff (rst_i)
    fpu_fire |-> free_q[alloc_tag]);
  a_load_single: assert property (@(posedge clk_i) disable iff (rst_i)
    load_fire |-> !load_busy_q);
  a_idle_sb_clear: assert property (@(posedge clk_i) disable iff (rst_i)
    !busy_o |-> (sb_vec == '0));
  a_ret_live_tag: assert property (@(posedge clk_i) disable iff (rst_i)
    (fpu_out_valid_i && fpu_out_ready_o) |-> ret_live);

endmodule

// File: tb/tb_fpu_ss_issue.sv
// Directed bench for fpu_ss_issue: FPR writes and C-responses are scored against
// expectation queues filled as stimulus is driven; cycle-level stalls checked inline.
module tb_fpu_ss_issue;
  import fpu_ss_pkg::*;

  localparam logic [1:0] K_DIRECT = 2'd0, K_FPU = 2'd1, K_LOAD = 2'd2, K_STORE = 2'd3;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        instr_valid_i, instr_ready_o;
  logic [14:0] rs_addr_i;
  logic [2:0]  rs_used_i;
  logic [4:0]  rd_i;
  logic        rd_is_fp_i, use_fpu_i, is_load_i, is_store_i;
  logic        fpu_in_valid_o, fpu_in_ready_i;
  logic [1:0]  fpu_tag_o;
  logic        fpu_out_valid_i, fpu_out_ready_o;
  logic [1:0]  fpu_tag_i;
  logic        mem_q_valid_o, mem_q_ready_i, mem_p_valid_i, mem_p_ready_o;
  logic        fpr_we_o;
  logic [4:0]  fpr_waddr_o;
  logic [1:0]  fpr_wsrc_o;
  logic        c_p_valid_o, c_p_ready_i;
  logic [4:0]  c_p_rd_o;
  logic        c_p_src_o, busy_o;

  always #5 clk = ~clk;

  fpu_ss_issue #(.NUM_TAGS(4), .NUM_FPR(32)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o),
    .rs_addr_i(rs_addr_i), .rs_used_i(rs_used_i), .rd_i(rd_i), .rd_is_fp_i(rd_is_fp_i),
    .use_fpu_i(use_fpu_i), .is_load_i(is_load_i), .is_store_i(is_store_i),
    .fpu_in_valid_o(fpu_in_valid_o), .fpu_in_ready_i(fpu_in_ready_i), .fpu_tag_o(fpu_tag_o),
    .fpu_out_valid_i(fpu_out_valid_i), .fpu_out_ready_o(fpu_out_ready_o), .fpu_tag_i(fpu_tag_i),
    .mem_q_valid_o(mem_q_valid_o), .mem_q_ready_i(mem_q_ready_i),
    .mem_p_valid_i(mem_p_valid_i), .mem_p_ready_o(mem_p_ready_o),
    .fpr_we_o(fpr_we_o), .fpr_waddr_o(fpr_waddr_o), .fpr_wsrc_o(fpr_wsrc_o),
    .c_p_valid_o(c_p_valid_o), .c_p_ready_i(c_p_ready_i), .c_p_rd_o(c_p_rd_o),
    .c_p_src_o(c_p_src_o), .busy_o(busy_o)
  );

  int         n_vec = 0;
  int         n_err = 0;
  logic [6:0] exp_fpr[$];
  logic [5:0] exp_cp[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    instr_valid_i = 1'b0; use_fpu_i = 1'b0; is_load_i = 1'b0; is_store_i = 1'b0;
    rd_i = '0; rd_is_fp_i = 1'b0; rs_addr_i = '0; rs_used_i = '0;
    fpu_out_valid_i = 1'b0; fpu_tag_i = '0; mem_p_valid_i = 1'b0;
  endtask

  task automatic op(input logic [1:0] kind, input logic [4:0] d, input logic dfp,
                    input logic [4:0] r1, input logic [4:0] r2, input logic [2:0] used);
    instr_valid_i = 1'b1;
    use_fpu_i  = (kind == K_FPU);
    is_load_i  = (kind == K_LOAD);
    is_store_i = (kind == K_STORE);
    rd_i = d; rd_is_fp_i = dfp;
    rs_addr_i = {5'd0, r2, r1}; rs_used_i = used;
  endtask

  task automatic ret(input logic [1:0] tag);
    fpu_out_valid_i = 1'b1;
    fpu_tag_i = tag;
  endtask

  task automatic push_fpr(input logic [1:0] src, input logic [4:0] addr);
    exp_fpr.push_back({src, addr});
  endtask

  // Scoreboard side: every write / accepted response must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst_i) begin
      if (fpr_we_o) begin
        if (exp_fpr.size() == 0) check_eq("fpr_extra", 32'({fpr_wsrc_o, fpr_waddr_o}), 32'hffff_ffff);
        else check_eq("fpr_write", 32'({fpr_wsrc_o, fpr_waddr_o}), 32'(exp_fpr.pop_front()));
      end
      if (c_p_valid_o && c_p_ready_i) begin
        if (exp_cp.size() == 0) check_eq("cp_extra", 32'({c_p_src_o, c_p_rd_o}), 32'hffff_ffff);
        else check_eq("cp_resp", 32'({c_p_src_o, c_p_rd_o}), 32'(exp_cp.pop_front()));
      end
    end
  end

  task automatic check_quiet(input string pfx);
    check_eq({pfx, "_instr_ready"}, 32'(instr_ready_o), 0);
    check_eq({pfx, "_fpu_in_valid"}, 32'(fpu_in_valid_o), 0);
    check_eq({pfx, "_mem_q_valid"}, 32'(mem_q_valid_o), 0);
    check_eq({pfx, "_mem_p_ready"}, 32'(mem_p_ready_o), 0);
    check_eq({pfx, "_fpu_out_ready"}, 32'(fpu_out_ready_o), 0);
    check_eq({pfx, "_fpr_we"}, 32'(fpr_we_o), 0);
    check_eq({pfx, "_c_p_valid"}, 32'(c_p_valid_o), 0);
    check_eq({pfx, "_fpu_tag"}, 32'(fpu_tag_o), 0);
    check_eq({pfx, "_busy"}, 32'(busy_o), 0);
  endtask

  initial begin
    idle();
    rst_i = 1'b1; fpu_in_ready_i = 1'b1; mem_q_ready_i = 1'b1; c_p_ready_i = 1'b0;
    repeat (2) cyc();
    rst_i = 1'b0;
    #1 check_quiet("reset");
    c_p_ready_i = 1'b1;

    // RAW stall: fmul f4 <- f3 waits for tag0, then one bubble.
    cyc(); op(K_FPU, 5'd3, 1'b1, 5'd1, 5'd2, 3'b011);
    #1 check_eq("fadd_issue", 32'(instr_ready_o), 1); check_eq("fadd_tag", 32'(fpu_tag_o), 0);
    cyc(); op(K_FPU, 5'd4, 1'b1, 5'd3, 5'd0, 3'b001);
    #1 check_eq("raw_stall", 32'(instr_ready_o), 0); check_eq("raw_busy", 32'(busy_o), 1);
    cyc(); ret(2'd0); push_fpr(WB_FPU, 5'd3);
    #1 check_eq("raw_bubble", 32'(instr_ready_o), 0); check_eq("ret_ready", 32'(fpu_out_ready_o), 1);
    cyc(); fpu_out_valid_i = 1'b0;
    #1 check_eq("raw_issue", 32'(instr_ready_o), 1); check_eq("raw_tag", 32'(fpu_tag_o), 0);
    cyc(); idle(); ret(2'd0); push_fpr(WB_FPU, 5'd4);
    cyc(); idle();
    #1 check_eq("t1_idle", 32'(busy_o), 0);

    // Tag exhaustion and lowest-free reuse.
    for (int i = 0; i < 4; i++) begin
      cyc(); op(K_FPU, 5'(8 + i), 1'b1, 5'd0, 5'd0, 3'b000);
      #1 check_eq("fill_issue", 32'(instr_ready_o), 1); check_eq("fill_tag", 32'(fpu_tag_o), 32'(i));
    end
    cyc(); op(K_FPU, 5'd12, 1'b1, 5'd0, 5'd0, 3'b000);
    #1 check_eq("tags_full", 32'(instr_ready_o), 0); check_eq("tags_full_vld", 32'(fpu_in_valid_o), 0);
    cyc(); ret(2'd2); push_fpr(WB_FPU, 5'd10);
    #1 check_eq("tag_free_late", 32'(instr_ready_o), 0);
    cyc(); fpu_out_valid_i = 1'b0;
    #1 check_eq("tag_reuse_issue", 32'(instr_ready_o), 1); check_eq("tag_reuse", 32'(fpu_tag_o), 2);

    // Out-of-order returns; store rs2 probes (no handshake) observe scoreboard bits.
    cyc(); idle(); mem_q_ready_i = 1'b0; op(K_STORE, 5'd0, 1'b0, 5'd0, 5'd9, 3'b010);
    ret(2'd1); push_fpr(WB_FPU, 5'd9);
    #1 check_eq("sb_f9_set", 32'(mem_q_valid_o), 0);
    cyc(); ret(2'd0); push_fpr(WB_FPU, 5'd8);
    #1 check_eq("sb_f9_clr", 32'(mem_q_valid_o), 1);
    cyc(); fpu_out_valid_i = 1'b0; rs_addr_i = {5'd0, 5'd8, 5'd0};
    #1 check_eq("sb_f8_clr", 32'(mem_q_valid_o), 1);
    cyc(); rs_addr_i = {5'd0, 5'd11, 5'd0}; ret(2'd3); push_fpr(WB_FPU, 5'd11);
    #1 check_eq("sb_f11_set", 32'(mem_q_valid_o), 0);
    cyc(); idle(); mem_q_ready_i = 1'b1; ret(2'd2); push_fpr(WB_FPU, 5'd12);
    cyc(); idle();
    #1 check_eq("t2_idle", 32'(busy_o), 0);

    // Direct ops and their yield to an FPU write-back.
    cyc(); op(K_DIRECT, 5'd13, 1'b1, 5'd0, 5'd0, 3'b000); push_fpr(WB_DIRECT, 5'd13);
    #1 check_eq("fmv_fp", 32'(instr_ready_o), 1);
    cyc(); op(K_DIRECT, 5'd9, 1'b0, 5'd1, 5'd0, 3'b001); exp_cp.push_back({1'b1, 5'd9});
    #1 check_eq("fmv_x", 32'(instr_ready_o), 1); check_eq("fmv_x_cp", 32'(c_p_valid_o), 1);
    cyc(); op(K_FPU, 5'd14, 1'b1, 5'd0, 5'd0, 3'b000);
    #1 check_eq("f14_issue", 32'(instr_ready_o), 1);
    cyc(); op(K_DIRECT, 5'd15, 1'b1, 5'd0, 5'd0, 3'b000); ret(2'd0); push_fpr(WB_FPU, 5'd14);
    #1 check_eq("direct_yield", 32'(instr_ready_o), 0);
    cyc(); fpu_out_valid_i = 1'b0; push_fpr(WB_DIRECT, 5'd15);
    #1 check_eq("direct_go", 32'(instr_ready_o), 1);

    // Load write-back collides with an FPU return.
    cyc(); idle(); op(K_FPU, 5'd6, 1'b1, 5'd0, 5'd0, 3'b000);
    #1 check_eq("f6_issue", 32'(instr_ready_o), 1);
    cyc(); op(K_LOAD, 5'd5, 1'b1, 5'd0, 5'd0, 3'b000);
    #1 check_eq("flw_q_valid", 32'(mem_q_valid_o), 1); check_eq("flw_issue", 32'(instr_ready_o), 1);
    cyc(); op(K_LOAD, 5'd7, 1'b1, 5'd0, 5'd0, 3'b000); mem_q_ready_i = 1'b0;
    #1 check_eq("load_single", 32'(mem_q_valid_o), 0); check_eq("mem_p_ready", 32'(mem_p_ready_o), 1);
    cyc(); idle(); mem_q_ready_i = 1'b1; mem_p_valid_i = 1'b1; ret(2'd0); push_fpr(WB_LOAD, 5'd5);
    #1 check_eq("fpu_yield_load", 32'(fpu_out_ready_o), 0);
    cyc(); mem_p_valid_i = 1'b0; push_fpr(WB_FPU, 5'd6);
    #1 check_eq("fpu_after_load", 32'(fpu_out_ready_o), 1);
    cyc(); idle();
    #1 check_eq("t4_idle", 32'(busy_o), 0);

    // fcvt.w.s x7: response held while c_p_ready_i is low.
    cyc(); op(K_FPU, 5'd7, 1'b0, 5'd1, 5'd0, 3'b001);
    #1 check_eq("fcvt_issue", 32'(instr_ready_o), 1);
    cyc(); idle(); c_p_ready_i = 1'b0; ret(2'd0);
    for (int k = 0; k < 3; k++) begin
      #1 check_eq("cp_hold_vld", 32'(c_p_valid_o), 1); check_eq("cp_hold_rd", 32'(c_p_rd_o), 7);
      check_eq("cp_hold_rdy", 32'(fpu_out_ready_o), 0); check_eq("cp_hold_busy", 32'(busy_o), 1);
      cyc();
    end
    c_p_ready_i = 1'b1; exp_cp.push_back({1'b0, 5'd7});
    #1 check_eq("cp_release", 32'(fpu_out_ready_o), 1);
    cyc(); idle();
    #1 check_eq("t5_idle", 32'(busy_o), 0);

    // Reset with three tags and a load in flight.
    for (int i = 0; i < 3; i++) begin
      cyc(); op(K_FPU, 5'(16 + i), 1'b1, 5'd0, 5'd0, 3'b000);
      #1 check_eq("pre_rst_issue", 32'(instr_ready_o), 1);
    end
    cyc(); op(K_LOAD, 5'd19, 1'b1, 5'd0, 5'd0, 3'b000);
    #1 check_eq("pre_rst_load", 32'(instr_ready_o), 1);
    cyc(); idle(); c_p_ready_i = 1'b0; rst_i = 1'b1;
    cyc(); rst_i = 1'b0;
    #1 check_quiet("midrst");
    c_p_ready_i = 1'b1;
    cyc(); op(K_FPU, 5'd16, 1'b1, 5'd0, 5'd0, 3'b000);
    #1 check_eq("post_rst_issue", 32'(instr_ready_o), 1); check_eq("post_rst_tag", 32'(fpu_tag_o), 0);
    cyc(); idle(); ret(2'd0); push_fpr(WB_FPU, 5'd16);
    cyc(); idle();
    #1 check_eq("t6_idle", 32'(busy_o), 0);

    cyc();
    check_eq("fpr_q_drained", 32'(exp_fpr.size()), 0);
    check_eq("cp_q_drained", 32'(exp_cp.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
